// File: rtl/ps2_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_rx_fifo_pkg
// Purpose : Shared definitions for the PS/2 receive FIFO block.
//           Provides the frame geometry, the default parameter values, the
//           receive FSM state encoding and the odd-parity helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package ps2_rx_fifo_pkg;

    localparam int FRAME_BITS         = 11;              // start + 8 data + parity + stop
    localparam int DATA_BITS          = FRAME_BITS - 3;
    localparam int DEF_DEPTH_LOG2     = 3;
    localparam int DEF_FILTER_LEN     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 50000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                           input logic                 par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo_sync_filter.sv
`default_nettype none
// ============================================================================
// Module  : ps2_rx_fifo_sync_filter
// Purpose : Two-flop synchronisers for the raw PS/2 clock and data pins plus a
//           run-length glitch filter on the clock. The filtered clock only
//           changes after FILTER_LEN consecutive synchronised samples disagree
//           with it; a 1-cycle strobe marks each filtered falling edge.
// Ports   : clk, rst        system clock, synchronous active-high reset
//           ps2Clk, ps2Data raw asynchronous pin levels
//           clk_filt        filtered PS/2 clock (reset value 1)
//           data_sync       synchronised PS/2 data
//           strobe          1-cycle pulse on each filtered falling edge
// Rev     : 1.0  initial release
// ============================================================================
module ps2_rx_fifo_sync_filter
    import ps2_rx_fifo_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2Clk,
    input  logic ps2Data,
    output logic clk_filt,
    output logic data_sync,
    output logic strobe
);

    localparam int              CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             clk_meta;
    logic             clk_sync;
    logic             data_meta;
    logic [CNT_W-1:0] run_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            clk_filt  <= 1'b1;
            run_len   <= '0;
            strobe    <= 1'b0;
        end else begin
            clk_meta  <= ps2Clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2Data;
            data_sync <= data_meta;
            strobe    <= 1'b0;
            // run_len counts how many samples in a row differ from clk_filt;
            // any agreeing sample restarts the count, which rejects glitches.
            if (clk_sync != clk_filt) begin
                if (run_len == CNT_LAST) begin
                    clk_filt <= clk_sync;
                    run_len  <= '0;
                    strobe   <= ~clk_sync;
                end else begin
                    run_len <= run_len + 1'b1;
                end
            end else begin
                run_len <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ps2_rx_fifo
// Purpose : PS/2 device-to-host receiver. Frames are deserialised by a small
//           FSM, checked for stop bit / odd parity / inter-edge timeout, and
//           good bytes are queued in a first-word fall-through FIFO.
// Config  : PS2_INHIBIT_EN  when defined, inhibit is a registered "FIFO full"
//                           request; otherwise inhibit is tied low.
// Ports   : clk, rst     system clock, synchronous active-high reset
//           ps2Clk       raw PS/2 clock pin      ps2Data   raw PS/2 data pin
//           rdEn         pop request (ignored while rdValid=0)
//           rdData       head byte, valid with rdValid
//           rdValid      FIFO not empty          count     bytes held
//           parityErr    pulse: bad parity       frameErr  pulse: bad stop/timeout
//           overflow     pulse: good byte dropped, FIFO full
//           inhibit      request to hold the PS/2 clock low
// Rev     : 1.0  initial release
// ============================================================================
module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2     = DEF_DEPTH_LOG2,
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2Clk,
    input  logic                  ps2Data,
    input  logic                  rdEn,
    output logic [7:0]            rdData,
    output logic                  rdValid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  parityErr,
    output logic                  frameErr,
    output logic                  overflow,
    output logic                  inhibit
);

    localparam int                  DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam int                  TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int                  BW     = $clog2(DATA_BITS);
    localparam logic [BW-1:0]       BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [TW-1:0]       T_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic clk_filt;
    logic data_sync;
    logic strobe;
    logic bit_strobe;

    ps2_rx_fifo_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
        .clk       (clk),
        .rst       (rst),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .clk_filt  (clk_filt),
        .data_sync (data_sync),
        .strobe    (strobe)
    );

    // The strobe is only raised together with the filtered clock going low.
    assign bit_strobe = strobe & ~clk_filt;

    // ------------------------------------------------------------------
    // Receive FSM and inter-edge timeout
    // ------------------------------------------------------------------
    rx_state_t          state, state_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [BW-1:0]      bit_cnt, bit_cnt_nxt;
    logic               par_bit, par_bit_nxt;
    logic [TW-1:0]      tcnt, tcnt_nxt;
    logic               parity_err_nxt, frame_err_nxt;
    logic               push_req, push_req_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            tcnt      <= '0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
            push_req  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            par_bit   <= par_bit_nxt;
            tcnt      <= tcnt_nxt;
            parityErr <= parity_err_nxt;
            frameErr  <= frame_err_nxt;
            push_req  <= push_req_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        bit_cnt_nxt    = bit_cnt;
        par_bit_nxt    = par_bit;
        parity_err_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        push_req_nxt   = 1'b0;

        // tcnt holds the number of cycles elapsed since the last strobe.
        if (bit_strobe) begin
            tcnt_nxt = TW'(1);
        end else if (state == ST_IDLE) begin
            tcnt_nxt = '0;
        end else begin
            tcnt_nxt = tcnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (bit_strobe && !data_sync) begin
                    state_nxt   = ST_DATA;
                    bit_cnt_nxt = '0;
                end
            end
            ST_DATA: begin
                if (bit_strobe) begin
                    shreg_nxt   = {data_sync, shreg[DATA_BITS-1:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_strobe) begin
                    par_bit_nxt = data_sync;
                    state_nxt   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_strobe) begin
                    state_nxt = ST_IDLE;
                    if (!data_sync) begin
                        frame_err_nxt = 1'b1;
                    end else if (!odd_parity_ok(shreg, par_bit)) begin
                        parity_err_nxt = 1'b1;
                    end else begin
                        push_req_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Registered pulse lands exactly TIMEOUT_CYCLES after the last strobe.
        if (state != ST_IDLE && !bit_strobe && tcnt == T_LAST) begin
            state_nxt     = ST_IDLE;
            frame_err_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO. The full/overflow decision is taken in the push cycle so that a
    // simultaneous pop frees the slot the push needs.
    // ------------------------------------------------------------------
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  do_pop;
    logic                  do_push;

    assign rdValid  = (count != '0);
    assign rdData   = rdValid ? mem[rd_ptr] : 8'h00;
    assign do_pop   = rdEn && rdValid;
    assign do_push  = push_req && ((count != FULL) || do_pop);
    assign overflow = push_req && (count == FULL) && !do_pop;

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
        end
    end

    // Storage needs no reset: rdValid masks unwritten entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

`ifdef PS2_INHIBIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inhibit <= 1'b0;
        end else begin
            inhibit <= (count_nxt == FULL);
        end
    end
`else
    assign inhibit = 1'b0;
`endif

endmodule
`default_nettype wire
